// File: rtl/avalon_lsu_if.sv
// Avalon-MM master port bundle between the load/store unit and memory.
interface avalon_lsu_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_lsu.sv
// Load/store unit: one core data request at a time, mapped onto a word-aligned
// Avalon-MM read/write with byte enables, waitrequest handling, load
// alignment/extension and an optional waitrequest watchdog.
module avalon_lsu #(
    parameter int WAIT_LIMIT = 0,   // 0 disables the watchdog
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    avalon_lsu_if.master av
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t             state_q, state_d;
    logic               we_q, signed_q;
    logic [1:0]         size_q, off_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_err, timeout;
    logic [3:0]         be_d;
    logic [31:0]        wd_d;
    logic [15:0]        half_sel;
    logic [7:0]         byte_sel;
    logic [31:0]        load_val;

    assign busy_o  = (state_q != IDLE);
    assign timeout = (WAIT_LIMIT != 0) && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

    // Reject reserved sizes and accesses not naturally aligned to their size
    always_comb begin
        req_err = 1'b0;
        case (size_i)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = addr_i[0];
            2'b10:   req_err = |addr_i[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        be_d = 4'b1111;
        wd_d = wdata_i;
        case (size_i)
            2'b00: begin
                be_d = 4'b0001 << addr_i[1:0];
                wd_d = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_d = 4'b0011 << addr_i[1:0];
                wd_d = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of readdata and extend it to 32 bits
    always_comb begin
        half_sel = off_q[1] ? av.readdata[31:16] : av.readdata[15:0];
        byte_sel = off_q[0] ? half_sel[15:8] : half_sel[7:0];
        case (size_q)
            2'b00:   load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_val = av.readdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state: bad requests skip the bus and report straight away
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = req_err ? RESP : BUS;
            BUS:     if (!av.waitrequest || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered bus, response and request-context outputs
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            we_q          <= 1'b0;
            signed_q      <= 1'b0;
            size_q        <= 2'b00;
            off_q         <= 2'b00;
            cnt_q         <= '0;
            rdata_o       <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            av.address    <= '0;
            av.read       <= 1'b0;
            av.write      <= 1'b0;
            av.writedata  <= '0;
            av.byteenable <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: if (req_i) begin
                    we_q          <= we_i;
                    signed_q      <= signed_i;
                    size_q        <= size_i;
                    off_q         <= addr_i[1:0];
                    cnt_q         <= '0;
                    av.address    <= {addr_i[31:2], 2'b00};
                    av.byteenable <= be_d;
                    av.writedata  <= wd_d;
                    if (req_err) begin
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                    end else begin
                        av.read  <= ~we_i;
                        av.write <= we_i;
                    end
                end
                BUS: begin
                    if (!av.waitrequest) begin
                        av.read  <= 1'b0;
                        av.write <= 1'b0;
                        done_o   <= 1'b1;
                        if (!we_q) rdata_o <= load_val;
                    end else if (timeout) begin
                        // Abort: rdata_o keeps the last completed load
                        av.read  <= 1'b0;
                        av.write <= 1'b0;
                        err_o    <= 1'b1;
                        done_o   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP:    err_o <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_lsu.sv
// Self-checking bench for avalon_lsu: directed transactions with literal
// expectations plus a cycle-by-cycle comparison against a behavioural model.
module tb_avalon_lsu;
    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        req_i = 1'b0, we_i = 1'b0, signed_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [31:0] rdata_o;
    logic        done_o, err_o, busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    avalon_lsu_if bif();

    avalon_lsu #(.WAIT_LIMIT(WL), .CNT_W(16)) dut (
        .clk(clk), .reset_n_i(reset_n_i), .req_i(req_i), .we_i(we_i),
        .size_i(size_i), .signed_i(signed_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .av(bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_bad(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        if (n == 0) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be = '0;
        int n = nbytes(sz);
        int o = int'(off);
        for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] wd);
        case (nbytes(sz))
            1:       return (wd & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (wd & 32'h0000_FFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] v, top;
        int n = nbytes(sz);
        if (n == 4) return rd;
        v   = rd >> (8 * int'(off));
        top = 32'h1 << (8 * n);
        v   = v % top;
        if (sg && v >= (top >> 1)) v = v - top;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    int          m_phase = 0;     // 0 waiting, 1 on bus, 2 reporting
    int          m_waited = 0;
    logic        m_we = 1'b0, m_sgn = 1'b0;
    logic [1:0]  m_size = 2'b00, m_off = 2'b00;
    logic        exp_read = 1'b0, exp_write = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wd = '0;
    logic [3:0]  exp_be = '0;
    logic        exp_busy;

    assign exp_busy = (m_phase != 0);

    always @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_phase <= 0; m_waited <= 0;
            exp_read <= 1'b0; exp_write <= 1'b0; exp_done <= 1'b0; exp_err <= 1'b0;
            exp_rdata <= '0; exp_addr <= '0; exp_wd <= '0; exp_be <= '0;
        end else begin
            exp_done <= 1'b0;
            case (m_phase)
                0: if (req_i) begin
                    m_we <= we_i; m_sgn <= signed_i; m_size <= size_i; m_off <= addr_i[1:0];
                    m_waited <= 0;
                    exp_addr <= addr_i & 32'hFFFF_FFFC;
                    exp_be   <= ref_be(size_i, addr_i[1:0]);
                    exp_wd   <= ref_wd(size_i, wdata_i);
                    if (ref_bad(size_i, addr_i)) begin
                        exp_err <= 1'b1; exp_done <= 1'b1; m_phase <= 2;
                    end else begin
                        exp_read <= !we_i; exp_write <= we_i; m_phase <= 1;
                    end
                end
                1: if (!bif.waitrequest) begin
                    exp_read <= 1'b0; exp_write <= 1'b0; exp_done <= 1'b1; m_phase <= 2;
                    if (!m_we) exp_rdata <= ref_load(m_size, m_sgn, m_off, bif.readdata);
                end else if (m_waited + 1 == WL) begin
                    exp_read <= 1'b0; exp_write <= 1'b0; exp_err <= 1'b1;
                    exp_done <= 1'b1; m_phase <= 2;
                end else begin
                    m_waited <= m_waited + 1;
                end
                default: begin
                    exp_err <= 1'b0; m_phase <= 0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_n_i) begin
            check("cyc read",  bif.read,  exp_read);
            check("cyc write", bif.write, exp_write);
            check("cyc done",  done_o,    exp_done);
            check("cyc err",   err_o,     exp_err);
            check("cyc busy",  busy_o,    exp_busy);
            check("cyc rdata", rdata_o,   exp_rdata);
            if (exp_read || exp_write) begin
                check("cyc address",    bif.address,    exp_addr);
                check("cyc byteenable", bif.byteenable, exp_be);
                check("cyc writedata",  bif.writedata,  exp_wd);
            end
        end
    end

    // One transaction with literal expectations; nwait = waitrequest cycles
    task automatic txn(input string name, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int nwait,
                       input int e_lat, input int e_bus, input logic [31:0] e_rdata,
                       input logic e_err, input logic [31:0] e_addr,
                       input logic [3:0] e_be, input logic [31:0] e_wd);
        int k = 0, bus = 0;
        logic seen = 1'b0;
        logic [31:0] s_addr = '0, s_wd = '0;
        logic [3:0]  s_be = '0;
        @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = sz; signed_i = sg; addr_i = a; wdata_i = wd;
        bif.readdata = rd; bif.waitrequest = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            req_i = 1'b0;
            if (bif.read || bif.write) begin
                bus++;
                s_addr = bif.address; s_be = bif.byteenable; s_wd = bif.writedata;
            end
            if (done_o) seen = 1'b1;
            bif.waitrequest = (k <= nwait);
        end
        bif.waitrequest = 1'b0;
        check({name, " done seen"}, seen, 1'b1);
        check({name, " latency"}, k, e_lat);
        check({name, " bus cycles"}, bus, e_bus);
        check({name, " rdata"}, rdata_o, e_rdata);
        check({name, " err"}, err_o, e_err);
        if (e_bus > 0) begin
            check({name, " address"}, s_addr, e_addr);
            check({name, " byteenable"}, s_be, e_be);
            check({name, " writedata"}, s_wd, e_wd);
        end
    endtask

    initial begin
        bif.waitrequest = 1'b0;
        bif.readdata    = '0;
        repeat (2) @(negedge clk);
        check("reset rdata", rdata_o, 32'h0);
        check("reset done",  done_o, 1'b0);
        check("reset err",   err_o, 1'b0);
        check("reset busy",  busy_o, 1'b0);
        check("reset read",  bif.read, 1'b0);
        check("reset write", bif.write, 1'b0);
        check("reset address", bif.address, 32'h0);
        reset_n_i = 1'b1;

        //   name        we  sz     sg  addr          wdata         readdata      nw lat bus rdata         err addr          be       wd
        txn("LW",        0, 2'b10, 0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 2, 1, 32'hDEAD_BEEF, 0, 32'h0000_1004, 4'b1111, 32'h0);
        txn("LB",        0, 2'b00, 1, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 2, 1, 32'hFFFF_FF80, 0, 32'h0000_1000, 4'b1000, 32'h0);
        txn("LBU",       0, 2'b00, 0, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 2, 1, 32'h0000_0080, 0, 32'h0000_1000, 4'b1000, 32'h0);
        txn("LHU",       0, 2'b01, 0, 32'h0000_1002, 32'h0,        32'h8012_3456, 0, 2, 1, 32'h0000_8012, 0, 32'h0000_1000, 4'b1100, 32'h0);
        txn("SB",        1, 2'b00, 0, 32'h0000_2001, 32'h0000_00A5, 32'h0,        3, 5, 4, 32'h0000_8012, 0, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5);
        txn("SH",        1, 2'b01, 0, 32'h0000_2002, 32'h1234_BEEF, 32'h0,        1, 3, 2, 32'h0000_8012, 0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
        txn("SW",        1, 2'b10, 0, 32'h0000_2004, 32'hCAFE_F00D, 32'h0,        0, 2, 1, 32'h0000_8012, 0, 32'h0000_2004, 4'b1111, 32'hCAFE_F00D);
        txn("LH",        0, 2'b01, 1, 32'h0000_1000, 32'h0,        32'h0000_F00D, 2, 4, 3, 32'hFFFF_F00D, 0, 32'h0000_1000, 4'b0011, 32'h0);
        txn("LH mis",    0, 2'b01, 1, 32'h0000_3001, 32'h0,        32'h1234_5678, 0, 1, 0, 32'hFFFF_F00D, 1, 32'h0,        4'b0000, 32'h0);
        txn("LW mis",    0, 2'b10, 0, 32'h0000_3002, 32'h0,        32'h1234_5678, 0, 1, 0, 32'hFFFF_F00D, 1, 32'h0,        4'b0000, 32'h0);
        txn("size11",    0, 2'b11, 0, 32'h0000_3000, 32'h0,        32'h1234_5678, 0, 1, 0, 32'hFFFF_F00D, 1, 32'h0,        4'b0000, 32'h0);
        txn("LW timeout",0, 2'b10, 0, 32'h0000_4000, 32'h0,        32'h1111_1111, 99, 5, 4, 32'hFFFF_F00D, 1, 32'h0000_4000, 4'b1111, 32'h0);
        txn("LB pos",    0, 2'b00, 1, 32'h0000_1001, 32'h0,        32'h0000_7F00, 0, 2, 1, 32'h0000_007F, 0, 32'h0000_1000, 4'b0010, 32'h0);

        // Reset in the middle of a stalled read
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; signed_i = 1'b0; addr_i = 32'h0000_5000;
        bif.waitrequest = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        check("midreset read before", bif.read, 1'b1);
        @(posedge clk);
        #2 reset_n_i = 1'b0;
        #1;
        check("midreset read",  bif.read, 1'b0);
        check("midreset write", bif.write, 1'b0);
        check("midreset busy",  busy_o, 1'b0);
        check("midreset done",  done_o, 1'b0);
        @(negedge clk);
        check("midreset no done", done_o, 1'b0);
        bif.waitrequest = 1'b0;
        reset_n_i = 1'b1;
        txn("LW after rst", 0, 2'b10, 0, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 0, 2, 1, 32'h0BAD_F00D, 0, 32'h0000_6000, 4'b1111, 32'h0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/avalon_lsu.md
Name: avalon_lsu

Overview:
- Load/store unit between the core datapath/control and the Avalon memory-mapped master port.
- Accepts one data-memory request at a time: LB/LBU/LH/LHU/LW and SB/SH/SW.
- Drives a word-aligned Avalon read/write and holds it until waitrequest deasserts.
- Aligns and extends read data; produces the stall and done signals the core FSM waits on, replacing the core's fixed byteenable of 1111 and its missing waitrequest handling.

Parameters:
- WAIT_LIMIT, 0: maximum cycles with waitrequest high before abort; 0 disables the watchdog.
- CNT_W, 16: width of the wait counter; WAIT_LIMIT must be below 2^CNT_W.

Ports:
- clk  input  1  system clock
- reset_n_i  input  1  reset, asynchronous, active-low
- req_i  input  1  request strobe from control, sampled only in IDLE
- we_i  input  1  1 = store, 0 = load
- size_i  input  2  00 byte, 01 half, 10 word, 11 reserved
- signed_i  input  1  loads only: 1 sign-extend, 0 zero-extend
- addr_i  input  32  byte address from ALU
- wdata_i  input  32  store data (rt), low-aligned
- rdata_o  output  32  aligned and extended load result
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  valid with done_o: misaligned, reserved size, or timeout
- busy_o  output  1  stall to core FSM; high when state != IDLE
- address  output  32  Avalon address, always {addr[31:2],2'b00}
- read  output  1  Avalon read
- write  output  1  Avalon write
- waitrequest  input  1  Avalon waitrequest
- writedata  output  32  Avalon write data, lane-replicated
- byteenable  output  4  Avalon byte enables
- readdata  input  32  Avalon read data

Behaviour:
- Clock and reset: one clock, clk. reset_n_i is asynchronous and active-low.
- Reset value of every output is 0; state goes to IDLE and the counter clears.
  - A reset mid-transaction drops read/write immediately. The transaction is abandoned with no done_o.
- States: IDLE, BUS, RESP. All outputs are registered except busy_o.
- IDLE, request accepted (req_i=1):
  - Latch we, size, signed, addr[1:0] and the aligned address.
  - Compute the error condition: size=11, half with addr[0]=1, or word with addr[1:0]!=0.
  - Error: go to RESP with err=1. read and write never assert.
  - Otherwise: go to BUS with read=~we_i and write=we_i. The bus request appears the cycle after acceptance.
- Byte lanes, little-endian, with off = addr[1:0]:
  - Byte: byteenable = 0001<<off; writedata = {4{wdata_i[7:0]}}.
  - Half: byteenable = 0011<<off; writedata = {2{wdata_i[15:0]}}.
  - Word: byteenable = 1111; writedata = wdata_i.
- BUS:
  - address, byteenable, writedata, read and write are held stable.
  - At a clock edge with waitrequest=0 the transfer completes: deassert read/write and go to RESP.
  - Load completion captures readdata the same edge, as follows:
    - Byte: select readdata[8*off+7 -: 8].
    - Half: select readdata[8*off+15 -: 16].
    - Extend to 32 bits per signed_i; word loads pass through.
  - Watchdog (WAIT_LIMIT>0):
    - The counter increments each BUS cycle with waitrequest=1.
    - When it reaches WAIT_LIMIT: deassert read/write, set err, go to RESP. rdata_o holds its previous value.
- RESP:
  - done_o=1 for exactly one cycle; rdata_o and err_o are valid.
  - Next state is IDLE.
  - err_o returns to 0 in IDLE. rdata_o holds until the next load completes.
- Latency: a zero-wait access gives done_o 2 cycles after acceptance; each waitrequest cycle adds 1.
- req_i in BUS or RESP is ignored. Control must wait for done_o before issuing a new request.
- Store completion leaves rdata_o unchanged.
- The counter clears on entry to BUS.

Test Plan:
- LW addr 0x0000_1004, waitrequest=0, readdata=0xDEADBEEF -> address=0x1004, byteenable=1111, read high 1 cycle, done_o 2 cycles after req, rdata_o=0xDEADBEEF, err_o=0.
- LB signed at 0x1003, readdata=0x80123456 -> byteenable=1000, rdata_o=0xFFFFFF80; LBU same -> 0x00000080; LHU at 0x1002 -> 0x00008012.
- SB wdata=0x000000A5 at 0x2001, waitrequest high 3 cycles -> write, address=0x2000, byteenable=0010, writedata=0xA5A5A5A5 held stable 4 cycles, done_o 5 cycles after req.
- LH at 0x3001 and LW at 0x3002 -> no read/write assertion, done_o next cycle with err_o=1; size=11 -> same.
- WAIT_LIMIT=4, waitrequest stuck high -> read drops after 4 BUS cycles, done_o with err_o=1, rdata_o unchanged.
- reset_n_i low during BUS -> read/write/busy_o go 0 asynchronously, no done_o; a new LW after release completes normally.
